pipeline_stall_ctrl: RTL

- Central stall/flush sequencer for the 5-stage integer pipeline.
- Decides, every cycle, the write enables and bubble/flush controls for the PC, IF/ID, ID/EX and EX/MEM registers.
- Arbitrates between three causes, in priority order: taken-branch redirect from MEM, the multi-cycle multiplier occupying EX, and load-use interlock between ID and EX.
- Sits beside the hazard/forwarding logic. Forwarding handles all RAW cases this block does not stall for.

---
 rtl/pipeline_stall_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Chooses the PC, IF/ID and ID/EX write enables and the bubble/flush controls
// each cycle. The causes, highest priority first, are a taken branch in MEM,
// the multi-cycle multiplier occupying EX, and a load-use interlock between
// ID and EX.
// Optional stall-cycle counter is enabled with the macro PIPE_STALL_COUNT_EN.
module pipeline_stall_ctrl #(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [0:4]  rs1_id,
  input  logic [0:4]  rs2_id,
  input  logic        uses_rs1_id,
  input  logic        uses_rs2_id,
  input  logic [0:4]  rd_ex,
  input  logic        regWrite_ex,
  input  logic        load_ex,
  input  logic        mul_start_ex,
  input  logic        branch_taken_mem,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        idex_we,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        exmem_bubble,
  output logic        mul_busy,
  output logic [31:0] stall_count
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    MBUSY = 2'b01
  } state_t;

  // A one-cycle multiply never stalls, so the counter preload only matters above 1
  localparam bit             MUL_STALLS = (MUL_LATENCY > 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             load_use;

  assign load_use = load_ex & regWrite_ex & (rd_ex != 5'd0) &
                    ((uses_rs1_id & (rs1_id == rd_ex)) |
                     (uses_rs2_id & (rs2_id == rd_ex)));

  // State and multiply down-counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and Mealy output decode, branch flush taking precedence everywhere
  always_comb begin
    state_next   = RUN;
    cnt_next     = cnt;
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    idex_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    mul_busy     = 1'b0;

    if (!reset_n) begin
      state_next = RUN;
      cnt_next   = '0;
    end else begin
      case (state)
        RUN: begin
          state_next = RUN;
          if (branch_taken_mem) begin
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
          end else if (mul_start_ex && MUL_STALLS) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_bubble = 1'b1;
            cnt_next     = CNT_LOAD;
            state_next   = MBUSY;
          end else if (load_use) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
          end
        end

        MBUSY: begin
          mul_busy = 1'b1;
          if (branch_taken_mem) begin
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
            cnt_next     = '0;
            state_next   = RUN;
          end else if (cnt != '0) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_we      = 1'b0;
            exmem_bubble = 1'b1;
            cnt_next     = cnt - 1'b1;
            state_next   = MBUSY;
          end else begin
            state_next = RUN;
          end
        end

        default: begin
          state_next = RUN;
          cnt_next   = '0;
        end
      endcase
    end
  end

`ifdef PIPE_STALL_COUNT_EN
  // Saturating count of cycles in which the PC was held
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (!pc_we && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`else
  assign stall_count = 32'd0;
`endif

endmodule
